rps_key_conditioner: RTL

//  Upstream input stage for the rock-paper-scissors pushbutton path.
//  - Synchronises the four raw active-low KEY inputs and debounces each one.
//  - Produces clean active-high levels, one-cycle press pulses and sticky capture bits.
//  - Records which key was pressed first since the last clear (player choice).
//  - Its outputs feed the system's pushbutton PIO in place of the raw inverted KEY bus.

---
 rtl/rps_pkg.sv | 28 ++
 rtl/rps_key_debounce.sv | 57 +++++
 rtl/rps_key_conditioner.sv | 84 ++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared constants and helpers for the rock-paper-scissors pushbutton path.
package rps_pkg;

  localparam int unsigned KEY_ROCK     = 0;
  localparam int unsigned KEY_PAPER    = 1;
  localparam int unsigned KEY_SCISSORS = 2;
  localparam int unsigned KEY_CONFIRM  = 3;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned KEY_IDX_W               = 2;
  localparam int unsigned MAX_KEYS                = 1 << KEY_IDX_W;

  typedef enum logic [0:0] {
    StIdle,
    StHeld
  } first_state_e;

  // Lowest set bit wins, so same-cycle presses resolve toward key 0.
  function automatic logic [KEY_IDX_W-1:0] lowest_index(input logic [MAX_KEYS-1:0] vec);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rps_key_debounce.sv
// One pushbutton: 2-FF synchroniser, saturating debounce counter, stable level and press pulse.
module rps_key_debounce
  import rps_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic pressed_o,
  output logic press_pulse_o
);

  localparam int unsigned     CntW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q;
  logic            key_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            pulse_q, pulse_d;

  // Synchroniser idles at 1 so a reset looks like a released key.
  assign key_s = ~sync_q[1];

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (key_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = key_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    pulse_d = db_d & ~db_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      pulse_q <= pulse_d;
    end
  end

  assign pressed_o     = db_q;
  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/rps_key_conditioner.sv
// Conditions the raw active-low KEY bus: debounced levels, press pulses, sticky
// capture bits and a first-key-pressed latch.
module rps_key_conditioner
  import rps_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned NUM_KEYS        = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_KEYS-1:0]  key_n_i,
  input  logic [NUM_KEYS-1:0]  clear_i,
  output logic [NUM_KEYS-1:0]  pressed_o,
  output logic [NUM_KEYS-1:0]  press_pulse_o,
  output logic [NUM_KEYS-1:0]  captured_o,
  output logic                 first_valid_o,
  output logic [KEY_IDX_W-1:0] first_key_o
);

  logic [NUM_KEYS-1:0]  press_pulse;
  logic [NUM_KEYS-1:0]  captured_q, captured_d;
  first_state_e         state_q, state_d;
  logic [KEY_IDX_W-1:0] first_key_q, first_key_d;
  logic                 any_pulse, any_clear;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    rps_key_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .key_n_i      (key_n_i[k]),
      .pressed_o    (pressed_o[k]),
      .press_pulse_o(press_pulse[k])
    );
  end

  assign any_pulse = |press_pulse;
  assign any_clear = |clear_i;

  // A new press always beats a clear landing in the same cycle.
  assign captured_d = (captured_q & ~clear_i) | press_pulse;

  always_comb begin
    state_d     = state_q;
    first_key_d = first_key_q;
    unique case (state_q)
      StIdle: begin
        if (any_pulse) begin
          state_d     = StHeld;
          first_key_d = lowest_index(MAX_KEYS'(press_pulse));
        end
      end
      StHeld: begin
        if (any_clear) begin
          if (any_pulse) begin
            first_key_d = lowest_index(MAX_KEYS'(press_pulse));
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      captured_q  <= '0;
      state_q     <= StIdle;
      first_key_q <= '0;
    end else begin
      captured_q  <= captured_d;
      state_q     <= state_d;
      first_key_q <= first_key_d;
    end
  end

  assign press_pulse_o = press_pulse;
  assign captured_o    = captured_q;
  assign first_valid_o = (state_q == StHeld);
  assign first_key_o   = first_key_q;

endmodule
